// File: rtl/pin_decoder.sv
// pin_decoder: turns an accepted pin number into a one-hot grant line that is held until that pin's done.
// The optional drive timeout is enabled by defining PIN_DECODER_TIMEOUT_EN.
module pin_decoder #(
    parameter int NPins   = 8,
    parameter int NIdx    = 3,
    parameter int Timeout = 16
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           inValid,
    input  logic [NIdx:0]  in,
    output logic           inReady,
    input  logic [NPins:0] done,
    output logic [NPins:0] out,
    output logic           outValid,
    output logic [NIdx:0]  outIndex,
    output logic           err,
    output logic           timedOut
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_e;

    if (Timeout < 1) begin : g_bad_timeout
        $error("pin_decoder: Timeout must be at least 1");
    end

    state_e          state_q, state_d;
    logic [NPins:0]  out_q, out_d;
    logic            outValid_q, outValid_d;
    logic [NIdx:0]   outIndex_q, outIndex_d;
    logic            inReady_q, inReady_d;
    logic            err_q, err_d;

`ifdef PIN_DECODER_TIMEOUT_EN
    localparam int CW = (Timeout > 1) ? $clog2(Timeout) : 1;
    localparam logic [CW-1:0] TMAX = CW'(Timeout - 1);

    logic [CW-1:0]   cnt_q, cnt_d;
    logic            timedOut_q, timedOut_d;
`endif

    always_comb begin
        state_d    = state_q;
        out_d      = out_q;
        outValid_d = outValid_q;
        outIndex_d = outIndex_q;
        err_d      = 1'b0;
`ifdef PIN_DECODER_TIMEOUT_EN
        cnt_d      = cnt_q;
        timedOut_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (inValid) begin
                    if (int'(in) <= NPins) begin
                        out_d      = {{NPins{1'b0}}, 1'b1} << in;
                        outIndex_d = in;
                        outValid_d = 1'b1;
                        state_d    = DRIVE;
`ifdef PIN_DECODER_TIMEOUT_EN
                        cnt_d      = '0;
`endif
                    end else begin
                        // Out-of-range request is consumed: inReady stays high in IDLE.
                        err_d = 1'b1;
                    end
                end
            end
            DRIVE: begin
`ifdef PIN_DECODER_TIMEOUT_EN
                if (cnt_q != TMAX) cnt_d = cnt_q + 1'b1;
`endif
                if (done[outIndex_q]) begin
                    out_d      = '0;
                    outValid_d = 1'b0;
                    state_d    = GAP;
                end
`ifdef PIN_DECODER_TIMEOUT_EN
                else if (cnt_q == TMAX) begin
                    out_d      = '0;
                    outValid_d = 1'b0;
                    timedOut_d = 1'b1;
                    state_d    = GAP;
                end
`endif
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Ready is a registered copy of "next state is IDLE", so it never sees inValid combinationally.
        inReady_d = (state_d == IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            out_q      <= '0;
            outValid_q <= 1'b0;
            outIndex_q <= '0;
            inReady_q  <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            outValid_q <= outValid_d;
            outIndex_q <= outIndex_d;
            inReady_q  <= inReady_d;
            err_q      <= err_d;
        end
    end

`ifdef PIN_DECODER_TIMEOUT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            timedOut_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            timedOut_q <= timedOut_d;
        end
    end

    assign timedOut = timedOut_q;
`else
    assign timedOut = 1'b0;
`endif

    assign out      = out_q;
    assign outValid = outValid_q;
    assign outIndex = outIndex_q;
    assign inReady  = inReady_q;
    assign err      = err_q;

endmodule

// File: tb/tb_pin_decoder.sv
// Bench for pin_decoder: directed vectors with literal expectations plus a per-cycle transaction model.
module tb_pin_decoder;

    localparam int NPINS   = 8;
    localparam int TIMEOUT = 4;
`ifdef PIN_DECODER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       inValid = 1'b0;
    logic [3:0] in = '0;
    logic [8:0] done = '0;
    logic       inReady, outValid, err, timedOut;
    logic [8:0] out;
    logic [3:0] outIndex;

    int n_tests = 0;
    int n_fail  = 0;

    pin_decoder #(.NPins(NPINS), .NIdx(3), .Timeout(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .inValid(inValid), .in(in), .inReady(inReady),
        .done(done), .out(out), .outValid(outValid), .outIndex(outIndex),
        .err(err), .timedOut(timedOut)
    );

    always #5 clock = ~clock;

    // Model: which pin is granted (-1 = none), whether the gap cycle is pending, and how long it has been driven.
    int m_pin = -1;
    int m_idx = 0;
    int m_age = 0;
    bit m_gap = 0;
    bit m_err = 0;
    bit m_to  = 0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_pin = -1; m_idx = 0; m_age = 0; m_gap = 0; m_err = 0; m_to = 0;
        end else begin
            m_err = 0;
            m_to  = 0;
            if (m_pin >= 0) begin
                m_age = m_age + 1;
                if (done[m_pin]) begin
                    m_pin = -1; m_gap = 1;
                end else if (TO_EN && m_age == TIMEOUT) begin
                    m_pin = -1; m_gap = 1; m_to = 1;
                end
            end else if (m_gap) begin
                m_gap = 0;
            end else if (inValid) begin
                if (int'(in) <= NPINS) begin
                    m_pin = int'(in); m_idx = int'(in); m_age = 0;
                end else begin
                    m_err = 1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            logic [8:0] e_out;
            e_out = '0;
            if (m_pin >= 0) e_out[m_pin] = 1'b1;
            n_tests++;
            if (out !== e_out || outValid !== (m_pin >= 0) || outIndex !== 4'(m_idx) ||
                inReady !== (m_pin < 0 && !m_gap) || err !== m_err || timedOut !== m_to ||
                $countones(out) > 1) begin
                n_fail++;
                $display("FAIL model t=%0t out=%b/%b valid=%b idx=%0d/%0d ready=%b err=%b/%b to=%b/%b",
                         $time, out, e_out, outValid, outIndex, m_idx, inReady, err, m_err, timedOut, m_to);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #1 reset = 1'b1;
        #21 reset = 1'b0;
        check("rst_out", 32'(out), 32'h0);
        check("rst_valid", 32'(outValid), 32'h0);
        check("rst_idx", 32'(outIndex), 32'h0);
        check("rst_ready", 32'(inReady), 32'h1);
        check("rst_err_to", 32'({err, timedOut}), 32'h0);

        // Pin 5, ignore foreign done bits, then release.
        step(); inValid = 1'b1; in = 4'd5;
        step(); inValid = 1'b0;
        check("p5_out", 32'(out), 32'h020);
        check("p5_idx", 32'(outIndex), 32'd5);
        check("p5_ready", 32'(inReady), 32'h0);
        done = 9'b000001000;
        step(); done = 9'b000000001;
        check("p5_ign3", 32'(out), 32'h020);
        step(); done = 9'b000100000;
        check("p5_ign0", 32'(out), 32'h020);
        step(); done = '0;
        check("p5_rel", 32'(out), 32'h0);
        check("p5_gap_ready", 32'(inReady), 32'h0);
        step();
        check("p5_ready_back", 32'(inReady), 32'h1);

        // Out-of-range request.
        inValid = 1'b1; in = 4'd12;
        step(); inValid = 1'b0;
        check("oor_err", 32'(err), 32'h1);
        check("oor_out", 32'(out), 32'h0);
        check("oor_ready", 32'(inReady), 32'h1);
        step();
        check("oor_err_once", 32'(err), 32'h0);

        // Back-to-back pins 2 then 7, both released immediately.
        inValid = 1'b1; in = 4'd2; done = 9'b010000100;
        step(); in = 4'd7;
        check("bb_p2", 32'(out), 32'h004);
        step();
        check("bb_gap", 32'(out), 32'h0);
        check("bb_gap_ready", 32'(inReady), 32'h0);
        step();
        check("bb_idle_out", 32'(out), 32'h0);
        step(); inValid = 1'b0;
        check("bb_p7", 32'(out), 32'h080);
        step(); done = '0;
        check("bb_p7_rel", 32'(out), 32'h0);
        step(); step();

        // Drive pin 1 with no done.
        inValid = 1'b1; in = 4'd1;
        step(); inValid = 1'b0;
        check("to_c1", 32'(out), 32'h002);
        repeat (3) step();
        check("to_c4", 32'(out), 32'h002);
        step();
        if (TO_EN) begin
            check("to_drop", 32'(out), 32'h0);
            check("to_pulse", 32'(timedOut), 32'h1);
            step();
            check("to_pulse_once", 32'(timedOut), 32'h0);
            check("to_ready", 32'(inReady), 32'h1);
            inValid = 1'b1; in = 4'd1;
            step(); inValid = 1'b0;
            repeat (3) step();
            done = 9'b000000010;
            step(); done = '0;
            check("to_done_wins_out", 32'(out), 32'h0);
            check("to_done_wins_to", 32'(timedOut), 32'h0);
            step(); step();
        end else begin
            check("noto_hold", 32'(out), 32'h002);
            check("noto_to", 32'(timedOut), 32'h0);
            repeat (4) step();
            check("noto_hold_long", 32'(out), 32'h002);
            done = 9'b000000010;
            step(); done = '0;
            check("noto_rel", 32'(out), 32'h0);
            step(); step();
        end

        // Asynchronous reset mid-drive on pin 6.
        inValid = 1'b1; in = 4'd6;
        step(); inValid = 1'b0;
        check("ar_drive", 32'(out), 32'h040);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("ar_out", 32'(out), 32'h0);
        check("ar_valid", 32'(outValid), 32'h0);
        check("ar_ready", 32'(inReady), 32'h1);
        #10 reset = 1'b0;
        step(); inValid = 1'b1; in = 4'd4;
        step(); inValid = 1'b0;
        check("ar_new_out", 32'(out), 32'h010);
        check("ar_new_idx", 32'(outIndex), 32'd4);
        done = 9'b000010000;
        step(); done = '0;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 100000", $time);
        $fatal(1);
    end

endmodule

// File: doc/pin_decoder.md
# pin_decoder

Inverse of the highest-active-pin mutex: accepts a pin number over a valid/ready handshake and drives exactly that output pin high (one-hot) until the pin's owner acknowledges on its `done` line. A mandatory one-cycle all-low gap follows each release (break-before-make). The block sits downstream of the mutex, turning the winning pin number back into a per-pin grant line.

## Interface
- `NPins`, 8, index of highest output pin; `out` is NPins+1 bits wide.
- `NIdx`, 3, index of highest bit of the pin-number bus (NIdx+1 bits).
- `Timeout`, 16, maximum cycles a pin may stay driven (used only with the timeout feature).

- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `inValid`  in  1  a pin number is offered on `in`.
- `in`  in  NIdx+1  pin number to drive.
- `inReady`  out  1  block accepts `in` on a rising edge where `inValid && inReady`.
- `done`  in  NPins+1  per-pin release; only the bit of the driven pin is observed.
- `out`  out  NPins+1  one-hot drive; all-low when idle.
- `outValid`  out  1  high while a pin is driven.
- `outIndex`  out  NIdx+1  number of the driven pin; holds its last value when idle.
- `err`  out  1  one-cycle pulse: an out-of-range pin number was offered.
- `timedOut`  out  1  one-cycle pulse: a drive was aborted by timeout (tied 0 without the feature).

## Operation
- States: IDLE, DRIVE, GAP. Reset enters IDLE.
- Reset values: `out`=0, `outValid`=0, `outIndex`=0, `inReady`=1, `err`=0, `timedOut`=0, drive counter=0. Reset clears all of these immediately, including mid-drive; `out` drops without waiting for a clock.
- IDLE, `inValid`=1, `in`<=NPins:
  - `out` <= 1<<`in`, `outIndex` <= `in`, `outValid` <= 1, `inReady` <= 0, counter <= 0.
  - Next state DRIVE.
- IDLE, `inValid`=1, `in`>NPins:
  - `err` <= 1 for one cycle; nothing else changes.
  - The request counts as consumed (handshake completes); state stays IDLE.
- DRIVE:
  - `out` is held; counter increments each cycle.
  - If `done[outIndex]`=1 on a rising edge: `out` <= 0, `outValid` <= 0, next state GAP.
  - `done` bits of other pins are ignored.
- GAP: `out`=0 and `inReady`=0 for exactly one cycle. Next state IDLE, with `inReady` <= 1.
- `inReady` is registered and never depends combinationally on `inValid`. `inValid` while `inReady`=0 is ignored and not queued.
- At most one `out` bit is high at any time. `out` is never high in IDLE or GAP.
- Counter saturates at `Timeout`-1. Its width is clog2(Timeout), minimum 1.

## Timing
- Latency: acceptance at edge E gives `out` high after edge E.
- `done` sampled high at edge D gives `out` low after edge D.
- After edge D: GAP through edge D+1, then `inReady`=1. Earliest next acceptance is edge D+2.
- A `done` already high at the first DRIVE edge (E+1) is honoured, so the minimum drive is 1 cycle.
- Back-to-back throughput: one transaction per (drive cycles + 2) cycles.
- `err` and `timedOut` are high for exactly one cycle after their triggering edge.

## Configuration
- `PIN_DECODER_TIMEOUT_EN` defined:
  - In DRIVE, if the counter equals `Timeout`-1 and `done[outIndex]`=0 on an edge: `out` <= 0, `outValid` <= 0, `timedOut` pulses, next state GAP.
  - If `done` and timeout coincide on the same edge, `done` wins and `timedOut` stays 0.
- `PIN_DECODER_TIMEOUT_EN` undefined:
  - No counter logic; DRIVE lasts until `done`.
  - `timedOut` is tied to 0; `Timeout` is unused.

## Test plan
- Reset then offer `in`=5: `out`=9'b000100000 and `outIndex`=5 one cycle after acceptance. Raise `done[5]`: `out`=0 next cycle, `inReady`=1 one cycle later.
- While driving pin 5, pulse `done[3]` and `done[0]`: `out` is unchanged. Then `done[5]` releases it.
- Offer `in`=12 with NPins=8: `err` pulses once, `out` stays 0, `inReady` stays 1.
- Hold `inValid` with pin 2 then pin 7 back to back, each released immediately:
  - Pin 2 drives for one cycle, followed by one all-low gap cycle.
  - Pin 7 is accepted at the D+2 edge and drives; pins 2 and 7 are never high together.
- With `PIN_DECODER_TIMEOUT_EN` and `Timeout`=4, drive pin 1 without `done`: `out` drops after exactly 4 DRIVE cycles and `timedOut` pulses. Repeating with `done[1]` on the 4th cycle gives `timedOut`=0.
- Assert `reset` asynchronously mid-DRIVE on pin 6: `out`=0, `outValid`=0 and `inReady`=1 immediately. After release, a new request is accepted normally.
